// File: rtl/flg_addr_gen_pkg.sv
// flg_addr_gen_pkg -- shared definitions for the flag-offset address generator.
//   DATA_WIDTH_DEF : flag word width
//   SRAM_AW_DEF    : compressed SRAM address width
//   DEPTH_DEF      : request FIFO depth
//   CNT_W_DEF      : width of a popcount of one flag word
//   req_t          : one read request {act_addr, wei_addr}
package flg_addr_gen_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SRAM_AW_DEF    = 10;
  localparam int DEPTH_DEF      = 4;
  // A popcount of N flags ranges 0..N, so it needs one bit more than log2(N).
  localparam int CNT_W_DEF      = $clog2(DATA_WIDTH_DEF) + 1;

  typedef struct packed {
    logic [SRAM_AW_DEF-1:0] act_addr;
    logic [SRAM_AW_DEF-1:0] wei_addr;
  } req_t;

endpackage

// File: rtl/flg_req_fifo.sv
// flg_req_fifo -- small request FIFO with count-based full/empty.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : synchronous flush; also zeroes the held head value
//   push, pushData : write one entry (caller never pushes into a full FIFO
//                    unless it pops in the same cycle)
//   pop         : remove the head (ignored when empty)
//   headVld     : FIFO non-empty
//   headData    : head entry; when empty, the last popped entry
//   full        : count == DEPTH
//
// Handshake: an entry transfers out on any edge where headVld & pop are
// both high; headVld/headData stay stable until that happens.
module flg_req_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             headVld,
  output logic [WIDTH-1:0] headData,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] lastPop;
  logic             doPop;

  assign headVld = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign doPop   = pop & headVld;

  // Once empty, the outputs keep showing the entry most recently consumed
  // rather than whatever stale word sits in the next slot.
  assign headData = headVld ? mem[rdPtr] : lastPop;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      lastPop <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (doPop) begin
        rdPtr   <= rdPtr + PW'(1);
        lastPop <= mem[rdPtr];
      end
      count <= count + CW'(push) - CW'(doPop);
    end
  end

  // Storage needs no reset: it is never observed while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/flg_addr_gen.sv
// flg_addr_gen -- turns flag-offset match results into absolute SRAM read
// addresses for the compressed activation and weight streams.
//   clk, rst_n            : clock, synchronous active-low reset
//   Clear                 : frame restart (flush FIFO, bases and flags to 0)
//   ValOffset             : offset pair valid (single-cycle pulse)
//   OffsetAct, OffsetWei  : 1-based flag counts at/above the matched position
//   WordLast              : last match of the current flag word
//   ActNnz, WeiNnz        : popcounts of the current flag words
//   OffRdy                : a ValOffset this cycle will be accepted
//   RdVld, RdRdy          : head request valid / consumer accepts
//   RdActAddr, RdWeiAddr  : head request addresses
//   Overflow              : sticky, a ValOffset arrived while OffRdy=0
//   NoMatch               : sticky, an accepted ValOffset had a zero offset
//
// Handshake: input side transfers when ValOffset & OffRdy & ~Clear; output
// side transfers when RdVld & RdRdy & ~Clear. ValOffset is not held by the
// producer, so a pulse seen with OffRdy low is lost (and flagged).
module flg_addr_gen
  import flg_addr_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SRAM_AW    = SRAM_AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Clear,
  input  logic                  ValOffset,
  input  logic [DATA_WIDTH-1:0] OffsetAct,
  input  logic [DATA_WIDTH-1:0] OffsetWei,
  input  logic                  WordLast,
  input  logic [CNT_W-1:0]      ActNnz,
  input  logic [CNT_W-1:0]      WeiNnz,
  output logic                  OffRdy,
  output logic                  RdVld,
  input  logic                  RdRdy,
  output logic [SRAM_AW-1:0]    RdActAddr,
  output logic [SRAM_AW-1:0]    RdWeiAddr,
  output logic                  Overflow,
  output logic                  NoMatch
);

  logic [SRAM_AW-1:0]   actBase;
  logic [SRAM_AW-1:0]   weiBase;
  logic [SRAM_AW-1:0]   actAddr;
  logic [SRAM_AW-1:0]   weiAddr;
  logic                 accept;
  logic                 zeroOff;
  logic                 push;
  logic                 pop;
  logic                 fifoFull;
  logic [2*SRAM_AW-1:0] headData;

  assign accept  = ValOffset & OffRdy & ~Clear;
  assign zeroOff = (OffsetAct == '0) | (OffsetWei == '0);
  assign push    = accept & ~zeroOff;
  assign pop     = RdVld & RdRdy & ~Clear;

  // A full FIFO can still take a push when its head leaves in the same cycle.
  assign OffRdy = ~fifoFull | (RdVld & RdRdy);

  // Offsets are 1-based; only the low SRAM_AW bits matter because the
  // address space wraps.
  assign actAddr = actBase + OffsetAct[SRAM_AW-1:0] - SRAM_AW'(1);
  assign weiAddr = weiBase + OffsetWei[SRAM_AW-1:0] - SRAM_AW'(1);

  flg_req_fifo #(
    .WIDTH (2*SRAM_AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (Clear),
    .push     (push),
    .pushData ({actAddr, weiAddr}),
    .pop      (pop),
    .headVld  (RdVld),
    .headData (headData),
    .full     (fifoFull)
  );

  assign RdActAddr = headData[2*SRAM_AW-1:SRAM_AW];
  assign RdWeiAddr = headData[SRAM_AW-1:0];

  // Bases advance after the address for this match has been formed, so a
  // push in the same cycle uses the old bases.
  always_ff @(posedge clk) begin
    if (!rst_n || Clear) begin
      actBase <= '0;
      weiBase <= '0;
    end else if (accept && WordLast) begin
      actBase <= actBase + SRAM_AW'(ActNnz);
      weiBase <= weiBase + SRAM_AW'(WeiNnz);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || Clear) begin
      Overflow <= 1'b0;
      NoMatch  <= 1'b0;
    end else begin
      if (ValOffset && !OffRdy) Overflow <= 1'b1;
      if (accept && zeroOff)    NoMatch  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flg_addr_gen.sv
// tb_flg_addr_gen -- directed self-checking bench for flg_addr_gen.
module tb_flg_addr_gen;

  localparam int DATA_WIDTH = 32;
  localparam int SRAM_AW    = 10;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 6;
  localparam int W          = 2 * SRAM_AW;

  logic                  clk;
  logic                  rst_n;
  logic                  Clear;
  logic                  ValOffset;
  logic [DATA_WIDTH-1:0] OffsetAct;
  logic [DATA_WIDTH-1:0] OffsetWei;
  logic                  WordLast;
  logic [CNT_W-1:0]      ActNnz;
  logic [CNT_W-1:0]      WeiNnz;
  logic                  OffRdy;
  logic                  RdVld;
  logic                  RdRdy;
  logic [SRAM_AW-1:0]    RdActAddr;
  logic [SRAM_AW-1:0]    RdWeiAddr;
  logic                  Overflow;
  logic                  NoMatch;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  flg_addr_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .SRAM_AW    (SRAM_AW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Clear     (Clear),
    .ValOffset (ValOffset),
    .OffsetAct (OffsetAct),
    .OffsetWei (OffsetWei),
    .WordLast  (WordLast),
    .ActNnz    (ActNnz),
    .WeiNnz    (WeiNnz),
    .OffRdy    (OffRdy),
    .RdVld     (RdVld),
    .RdRdy     (RdRdy),
    .RdActAddr (RdActAddr),
    .RdWeiAddr (RdWeiAddr),
    .Overflow  (Overflow),
    .NoMatch   (NoMatch)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; any pop happening on this edge is scored against exp_q first.
  task automatic step();
    if (RdVld && RdRdy && !Clear) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'(RdVld), 32'd0);
      else check("pop_order", 32'({RdActAddr, RdWeiAddr}), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one offset pulse; exp_push/ea/ew are the hand-computed result.
  task automatic pulse(input int oa, input int ow, input bit last, input int an, input int wn,
                       input bit exp_rdy, input bit exp_push, input int ea, input int ew);
    ValOffset = 1'b1;
    OffsetAct = DATA_WIDTH'(oa);
    OffsetWei = DATA_WIDTH'(ow);
    WordLast  = last;
    ActNnz    = CNT_W'(an);
    WeiNnz    = CNT_W'(wn);
    #1;
    check("offrdy", 32'(OffRdy), 32'(exp_rdy));
    if (exp_push) exp_q.push_back({SRAM_AW'(ea), SRAM_AW'(ew)});
    step();
    ValOffset = 1'b0;
    WordLast  = 1'b0;
    OffsetAct = '0;
    OffsetWei = '0;
  endtask

  task automatic check_head(input string tag, input bit vld, input int ea, input int ew);
    check({tag, "_vld"}, 32'(RdVld), 32'(vld));
    check({tag, "_act"}, 32'(RdActAddr), 32'(ea));
    check({tag, "_wei"}, 32'(RdWeiAddr), 32'(ew));
  endtask

  task automatic drain();
    RdRdy = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2 && RdVld; i++) step();
    check("drain_empty", 32'(RdVld), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; Clear = 1'b0; ValOffset = 1'b0; OffsetAct = '0; OffsetWei = '0;
    WordLast = 1'b0; ActNnz = '0; WeiNnz = '0; RdRdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_head("reset", 1'b0, 0, 0);
    check("reset_offrdy", 32'(OffRdy), 32'd1);
    check("reset_ovf", 32'(Overflow), 32'd0);
    check("reset_nomatch", 32'(NoMatch), 32'd0);

    // Single word: bases 0 -> (2,4), bases become 7,9 -> next word (7,9).
    pulse(3, 5, 1'b1, 7, 9, 1'b1, 1'b1, 2, 4);
    check_head("word0", 1'b1, 2, 4);
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 7, 9);
    check_head("word1", 1'b1, 7, 9);
    drain();
    check_head("hold_after_pop", 1'b0, 7, 9);

    // Backpressure: fill four entries with no pops.
    RdRdy = 1'b0;
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 7, 9);
    pulse(2, 3, 1'b0, 0, 0, 1'b1, 1'b1, 8, 11);
    pulse(3, 2, 1'b0, 0, 0, 1'b1, 1'b1, 9, 10);
    pulse(4, 4, 1'b0, 0, 0, 1'b1, 1'b1, 10, 12);
    check("full_offrdy", 32'(OffRdy), 32'd0);
    check_head("full_head", 1'b1, 7, 9);
    // Full FIFO with a pop in the same cycle still accepts.
    RdRdy = 1'b1;
    pulse(5, 5, 1'b0, 0, 0, 1'b1, 1'b1, 11, 13);
    check("pushpop_ovf", 32'(Overflow), 32'd0);
    check_head("pushpop_head", 1'b1, 8, 11);
    RdRdy = 1'b0;
    #1;
    check("pushpop_still_full", 32'(OffRdy), 32'd0);
    // Dropped pulse, even with WordLast: bases must not move.
    pulse(6, 6, 1'b1, 20, 20, 1'b0, 1'b0, 0, 0);
    check("drop_ovf", 32'(Overflow), 32'd1);
    check_head("drop_head", 1'b1, 8, 11);
    drain();
    check_head("drain_hold", 1'b0, 11, 13);
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 7, 9);
    check_head("bases_unchanged", 1'b1, 7, 9);
    drain();

    // Clear resets bases and flags.
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    exp_q.delete();
    check("clear_ovf", 32'(Overflow), 32'd0);
    check("clear_nomatch", 32'(NoMatch), 32'd0);
    check_head("clear", 1'b0, 0, 0);

    // Zero offset with WordLast: no entry, NoMatch, ActBase += 4.
    pulse(0, 1, 1'b1, 4, 0, 1'b1, 1'b0, 0, 0);
    check("zero_nomatch", 32'(NoMatch), 32'd1);
    check("zero_no_entry", 32'(RdVld), 32'd0);
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 4, 0);
    check_head("zero_base", 1'b1, 4, 0);

    // Walk ActBase to 4 + 31*32 + 24 = 1020, then OffsetAct=6 wraps to 1.
    for (int i = 0; i < 31; i++) pulse(0, 0, 1'b1, 32, 0, 1'b1, 1'b0, 0, 0);
    pulse(0, 0, 1'b1, 24, 0, 1'b1, 1'b0, 0, 0);
    pulse(6, 1, 1'b0, 0, 0, 1'b1, 1'b1, 1, 0);
    check_head("wrap", 1'b1, 1, 0);
    drain();

    // Clear with three queued entries and a concurrent ValOffset.
    RdRdy = 1'b0;
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 1020, 0);
    pulse(2, 2, 1'b0, 0, 0, 1'b1, 1'b1, 1021, 1);
    pulse(3, 3, 1'b0, 0, 0, 1'b1, 1'b1, 1022, 2);
    check_head("pre_clear", 1'b1, 1020, 0);
    Clear = 1'b1;
    ValOffset = 1'b1; OffsetAct = 2; OffsetWei = 2; WordLast = 1'b1; ActNnz = 5; WeiNnz = 5;
    step();
    Clear = 1'b0; ValOffset = 1'b0; WordLast = 1'b0;
    exp_q.delete();
    check_head("post_clear", 1'b0, 0, 0);
    check("post_clear_nomatch", 32'(NoMatch), 32'd0);
    check("post_clear_ovf", 32'(Overflow), 32'd0);
    RdRdy = 1'b1;
    pulse(1, 1, 1'b0, 0, 0, 1'b1, 1'b1, 0, 0);
    check_head("post_clear_base", 1'b1, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flg_addr_gen.md
# flg_addr_gen

Address generator downstream of the flag-offset stage in the sparse PE datapath. Converts each registered match result (activation/weight offsets within a 32-bit flag word) into absolute read addresses for the compressed activation and weight SRAMs. Tracks a per-stream base pointer across flag words and buffers requests in a small FIFO so MAC-side backpressure does not stall the offset stage.

## Interface
- DATA_WIDTH, 32: flag word width; offset inputs carry this width.
- SRAM_AW, 10: compressed-SRAM address width; all addresses wrap modulo 2^SRAM_AW.
- DEPTH, 4: request FIFO depth (power of two, ≥2).
- CNT_W, 6: width of the nonzero-count inputs, $clog2(DATA_WIDTH)+1.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- Clear  in  1  frame restart: flush FIFO, reload bases.
- ValOffset  in  1  offset pair valid (single-cycle pulse).
- OffsetAct  in  DATA_WIDTH  count of activation flags at/above the matched position.
- OffsetWei  in  DATA_WIDTH  same, weight flags.
- WordLast  in  1  with ValOffset: last match of current flag word.
- ActNnz  in  CNT_W  popcount of current activation flag word (sampled on WordLast).
- WeiNnz  in  CNT_W  popcount of current weight flag word.
- OffRdy  out  1  FIFO can accept this cycle.
- RdVld  out  1  head request valid.
- RdRdy  in  1  consumer accepts head.
- RdActAddr  out  SRAM_AW  activation SRAM read address.
- RdWeiAddr  out  SRAM_AW  weight SRAM read address.
- Overflow  out  1  sticky: a ValOffset was dropped.
- NoMatch  out  1  sticky: a ValOffset with a zero offset arrived.

## Operation
- Reset (rst_n=0 at clk edge): ActBase=WeiBase=0, FIFO empty, RdVld=0, RdActAddr=RdWeiAddr=0, OffRdy=1, Overflow=0, NoMatch=0.
- Accept = ValOffset & OffRdy & ~Clear.
- On Accept with OffsetAct≠0 and OffsetWei≠0: push {ActBase+OffsetAct−1, WeiBase+OffsetWei−1} (truncated to SRAM_AW, wrapping).
- Either offset zero: no push; set NoMatch; WordLast still applies.
- WordLast on Accept: ActBase+=ActNnz, WeiBase+=WeiNnz after address computation; push in the same cycle uses old bases.
- ValOffset & ~OffRdy & ~Clear: input discarded, Overflow set, bases unchanged even if WordLast.
- OffRdy = (count<DEPTH) | (RdVld & RdRdy): push into full FIFO legal when head pops same cycle.
- Pop when RdVld & RdRdy.
- Clear: FIFO emptied, bases to 0, Overflow/NoMatch cleared; concurrent ValOffset ignored; concurrent pop is a no-op.
- Offsets above DATA_WIDTH are not legal; behaviour undefined.

## Timing
- Latency: ValOffset at edge t → entry on RdVld/Rd*Addr after edge t+1 (registered FIFO, no bypass).
- Throughput: one push and one pop per cycle; full FIFO with RdRdy held high sustains 1/cycle.
- RdVld and addresses hold stable while RdRdy=0.
- Rd*Addr outputs hold last popped value when FIFO empty (not zeroed, except at reset/Clear → 0).
- Sticky flags update one cycle after the triggering edge's inputs; cleared only by rst_n or Clear.

## Structure
- Shared package: SRAM_AW default, CNT_W derivation, request struct {act_addr, wei_addr}.
- One sub-module: flg_req_fifo (DEPTH×2·SRAM_AW, count-based full/empty, simultaneous push/pop).
- Base registers, offset arithmetic and flags live in the top.

## Test plan
- Single word: bases 0, ValOffset OffsetAct=3 OffsetWei=5 WordLast=1 ActNnz=7 WeiNnz=9 → next cycle RdActAddr=2 RdWeiAddr=4; following word's OffsetAct=1 OffsetWei=1 → 7, 9.
- Backpressure: RdRdy=0, five consecutive ValOffset pulses, DEPTH=4 → OffRdy low after fourth, fifth dropped, Overflow=1, four entries drain in order once RdRdy=1.
- Full push+pop: FIFO full, RdRdy=1, ValOffset same cycle → accepted, count stays 4, no Overflow.
- Wrap: ActBase=1020, OffsetAct=6 → RdActAddr=1 (SRAM_AW=10).
- Zero offset with WordLast, ActNnz=4 → no entry, NoMatch=1, ActBase advances by 4.
- Clear mid-stream with 3 queued entries and ValOffset asserted → next cycle RdVld=0, bases 0, flags 0, that input absent.
